memwb_writeback_stage: RTL and testbench

//   MEM/WB pipeline register plus writeback formatting for the 5-stage MIPS pipeline.
//   - Captures EX/MEM results and the data-memory read word.
//   - Performs load byte/half extraction and sign/zero extension.
//   - Drives regwrite / writebackreg / data_towrite_memwb straight into the register file.
//   - Blocks writes to $0 and counts retired instructions.

---
 rtl/memwb_writeback_stage.sv | 139 +++++++++++++
 tb/tb_memwb_writeback_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_writeback_stage.sv
// memwb_writeback_stage
//   MEM/WB pipeline register plus writeback formatting for a 5-stage MIPS pipeline.
//   Captures the EX/MEM result and the data-memory read word, extracts and extends load
//   bytes/halves, drives the register-file write port, blocks writes to $0 and counts
//   retired instructions.
//
//   Optional feature macro: WB_BYPASS_EN adds a write-first bypass for the ID-stage
//   register read (ports rs, rt, rf_rd1, rf_rd2, fwd_rd1, fwd_rd2).
//
// Ports
//   clk, rst (async, active-low)         clock / reset
//   stall, flush                         hold / insert bubble (flush wins)
//   exmem_*                              EX/MEM slot contents
//   mem_rdata                            data-memory word at exmem_alu_result
//   regwrite, writebackreg,
//   data_towrite_memwb                   register-file write port
//   wb_valid                             WB slot holds a real instruction
//   retired_count                        instructions retired since reset (wraps)
module memwb_writeback_stage #(
  parameter int unsigned CNT_W      = 32,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             exmem_valid,
  input  logic             exmem_regwrite,
  input  logic             exmem_memtoreg,
  input  logic [2:0]       exmem_ldtype,
  input  logic [31:0]      exmem_alu_result,
  input  logic [4:0]       exmem_dest,
  input  logic [31:0]      mem_rdata,
  output logic             regwrite,
  output logic [4:0]       writebackreg,
  output logic [31:0]      data_towrite_memwb,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retired_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [31:0]      rf_rd1,
  input  logic [31:0]      rf_rd2,
  output logic [31:0]      fwd_rd1,
  output logic [31:0]      fwd_rd2
`endif
);

  localparam logic [2:0] LdLb  = 3'b001;
  localparam logic [2:0] LdLbu = 3'b010;
  localparam logic [2:0] LdLh  = 3'b011;
  localparam logic [2:0] LdLhu = 3'b100;

  logic             wb_valid_q, wb_valid_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       dest_q, dest_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Lane selection; big-endian mirrors the byte/half index within the word.
  always_comb begin
    byte_lane = BIG_ENDIAN ? (2'd3 - exmem_alu_result[1:0]) : exmem_alu_result[1:0];
    half_lane = BIG_ENDIAN ? ~exmem_alu_result[1] : exmem_alu_result[1];
    unique case (byte_lane)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = half_lane ? mem_rdata[31:16] : mem_rdata[15:0];
    // Reserved encodings fall through to a full-word load.
    case (exmem_ldtype)
      LdLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LdLbu:   ld_data = {24'd0, ld_byte};
      LdLh:    ld_data = {{16{ld_half[15]}}, ld_half};
      LdLhu:   ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    regwrite_d = regwrite_q;
    dest_d     = dest_q;
    data_d     = data_q;
    count_d    = count_q;
    if (flush) begin
      // Bubble: address and data are left as-is, only the enables drop.
      wb_valid_d = 1'b0;
      regwrite_d = 1'b0;
    end else if (!stall) begin
      wb_valid_d = exmem_valid;
      // The register file has no $0 protection, so writes to r0 are killed here.
      regwrite_d = exmem_valid & exmem_regwrite & (exmem_dest != 5'd0);
      dest_d     = exmem_dest;
      data_d     = exmem_memtoreg ? ld_data : exmem_alu_result;
      if (exmem_valid) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      regwrite_q <= 1'b0;
      dest_q     <= 5'd0;
      data_q     <= 32'd0;
      count_q    <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      regwrite_q <= regwrite_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
      count_q    <= count_d;
    end
  end

  assign wb_valid           = wb_valid_q;
  assign regwrite           = regwrite_q;
  assign writebackreg       = dest_q;
  assign data_towrite_memwb = data_q;
  assign retired_count      = count_q;

`ifdef WB_BYPASS_EN
  // Write-first bypass: the register file writes on the same posedge ID would sample,
  // so forward the pending write data to the ID read ports.
  always_comb begin
    fwd_rd1 = (regwrite_q && dest_q == rs && rs != 5'd0) ? data_q : rf_rd1;
    fwd_rd2 = (regwrite_q && dest_q == rt && rt != 5'd0) ? data_q : rf_rd2;
  end
`endif

endmodule

// File: tb/tb_memwb_writeback_stage.sv
module tb_memwb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        exmem_valid = 1'b0, exmem_regwrite = 1'b0, exmem_memtoreg = 1'b0;
  logic [2:0]  exmem_ldtype = '0;
  logic [31:0] exmem_alu_result = '0;
  logic [4:0]  exmem_dest = '0;
  logic [31:0] mem_rdata = '0;
  logic        regwrite, wb_valid, regwrite4, wb_valid4;
  logic [4:0]  writebackreg, writebackreg4;
  logic [31:0] data_towrite_memwb, data4;
  logic [31:0] retired_count;
  logic [3:0]  retired_count4;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs = '0, rt = '0;
  logic [31:0] rf_rd1 = '0, rf_rd2 = '0;
  logic [31:0] fwd_rd1, fwd_rd2, fwd4_rd1, fwd4_rd2;
`endif

  always #5 clk = ~clk;

  memwb_writeback_stage #(.CNT_W(32), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .exmem_valid(exmem_valid), .exmem_regwrite(exmem_regwrite),
    .exmem_memtoreg(exmem_memtoreg), .exmem_ldtype(exmem_ldtype),
    .exmem_alu_result(exmem_alu_result), .exmem_dest(exmem_dest), .mem_rdata(mem_rdata),
    .regwrite(regwrite), .writebackreg(writebackreg),
    .data_towrite_memwb(data_towrite_memwb), .wb_valid(wb_valid),
    .retired_count(retired_count)
`ifdef WB_BYPASS_EN
    , .rs(rs), .rt(rt), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2)
`endif
  );

  // Narrow-counter instance, used to observe counter wrap.
  memwb_writeback_stage #(.CNT_W(4), .BIG_ENDIAN(1'b0)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .exmem_valid(exmem_valid), .exmem_regwrite(exmem_regwrite),
    .exmem_memtoreg(exmem_memtoreg), .exmem_ldtype(exmem_ldtype),
    .exmem_alu_result(exmem_alu_result), .exmem_dest(exmem_dest), .mem_rdata(mem_rdata),
    .regwrite(regwrite4), .writebackreg(writebackreg4),
    .data_towrite_memwb(data4), .wb_valid(wb_valid4),
    .retired_count(retired_count4)
`ifdef WB_BYPASS_EN
    , .rs(rs), .rt(rt), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .fwd_rd1(fwd4_rd1), .fwd_rd2(fwd4_rd2)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic        m_valid, m_rw;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  longint      m_retired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Little-endian load extraction by shifting the addressed bytes down.
  function automatic logic [31:0] load_model(input logic [2:0] ldt, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned b, h;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (16 * addr[1])) & 32'hFFFF;
    case (ldt)
      3'd1:    return (b >= 128) ? b - 256 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return h;
      default: return word;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_dest = 0; m_data = 0; m_retired = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(m_valid));
    check({tag, ".regwrite"}, 32'(regwrite), 32'(m_rw));
    check({tag, ".writebackreg"}, 32'(writebackreg), 32'(m_dest));
    check({tag, ".data"}, data_towrite_memwb, m_data);
    check({tag, ".count"}, retired_count, 32'(m_retired % 64'h1_0000_0000));
    check({tag, ".count4"}, 32'(retired_count4), 32'(m_retired % 16));
`ifdef WB_BYPASS_EN
    check({tag, ".fwd1"}, fwd_rd1, (m_rw && m_dest == rs && rs != 0) ? m_data : rf_rd1);
    check({tag, ".fwd2"}, fwd_rd2, (m_rw && m_dest == rt && rt != 0) ? m_data : rf_rd2);
`endif
  endtask

  // Advance model with the inputs currently applied, clock once, compare.
  task automatic tick(input string tag);
    if (flush) begin
      m_valid = 0;
      m_rw = 0;
    end else if (!stall) begin
      m_valid = exmem_valid;
      m_rw = exmem_valid && exmem_regwrite && exmem_dest != 0;
      m_dest = exmem_dest;
      m_data = exmem_memtoreg ? load_model(exmem_ldtype, exmem_alu_result, mem_rdata)
                              : exmem_alu_result;
      if (exmem_valid) m_retired++;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] ldt,
                       input logic [31:0] alu, input logic [4:0] dst, input logic [31:0] rd);
    exmem_valid = v; exmem_regwrite = rw; exmem_memtoreg = m2r; exmem_ldtype = ldt;
    exmem_alu_result = alu; exmem_dest = dst; mem_rdata = rd;
  endtask

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [2:0]  ldt;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1, 0, 3'd0, 32'h0000_0038, 5'd5,  32'h0,         32'h0000_0038, 1};
    vecs[1] = '{1, 1, 3'd1, 32'h0000_1003, 5'd6,  32'h80FF_7F01, 32'hFFFF_FF80, 1};
    vecs[2] = '{1, 1, 3'd2, 32'h0000_1003, 5'd7,  32'h80FF_7F01, 32'h0000_0080, 1};
    vecs[3] = '{1, 1, 3'd3, 32'h0000_1002, 5'd8,  32'h80FF_7F01, 32'hFFFF_80FF, 1};
    vecs[4] = '{1, 1, 3'd4, 32'h0000_1000, 5'd9,  32'h80FF_7F01, 32'h0000_7F01, 1};
    vecs[5] = '{1, 1, 3'd0, 32'h0000_1001, 5'd10, 32'h80FF_7F01, 32'h80FF_7F01, 1};
    vecs[6] = '{1, 0, 3'd0, 32'h0000_1234, 5'd0,  32'h0,         32'h0000_1234, 0};
    vecs[7] = '{1, 1, 3'd7, 32'h0000_1002, 5'd11, 32'h80FF_7F01, 32'h80FF_7F01, 1};
    vecs[8] = '{1, 1, 3'd3, 32'h0000_1001, 5'd12, 32'h80FF_7F01, 32'h0000_7F01, 1};

    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;

    // Table-driven directed vectors against hand-derived constants.
    for (int i = 0; i < 9; i++) begin
      drive(1, vecs[i].rw, vecs[i].m2r, vecs[i].ldt, vecs[i].alu, vecs[i].dst, vecs[i].rdata);
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d.const_data", i), data_towrite_memwb, vecs[i].exp_data);
      check($sformatf("vec%0d.const_rw", i), 32'(regwrite), 32'(vecs[i].exp_rw));
      check($sformatf("vec%0d.const_valid", i), 32'(wb_valid), 32'd1);
    end
    check("vec.count_after_table", retired_count, 32'd9);

    // Stall three cycles with changing inputs, then flush with stall still high.
    drive(1, 1, 0, 3'd0, 32'h0000_00AA, 5'd17, 32'h0);
    tick("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 3'd0, $urandom, 5'(i + 20), $urandom);
      tick($sformatf("stall%0d", i));
      check($sformatf("stall%0d.const_data", i), data_towrite_memwb, 32'h0000_00AA);
      check($sformatf("stall%0d.const_count", i), retired_count, 32'd10);
    end
    flush = 1'b1;
    tick("flush_stall");
    check("flush.const_rw", 32'(regwrite), 32'd0);
    check("flush.const_valid", 32'(wb_valid), 32'd0);
    check("flush.const_dest", 32'(writebackreg), 32'd17);
    check("flush.const_count", retired_count, 32'd10);
    stall = 1'b0; flush = 1'b0;

`ifdef WB_BYPASS_EN
    drive(1, 1, 0, 3'd0, 32'hDEAD_BEEF, 5'd3, 32'h0);
    tick("byp_wr");
    rs = 5'd3; rf_rd1 = 32'h8; #1;
    check("byp.rs3", fwd_rd1, 32'hDEAD_BEEF);
    drive(1, 1, 0, 3'd0, 32'hDEAD_BEEF, 5'd0, 32'h0);
    tick("byp_wr0");
    rs = 5'd0; #1;
    check("byp.rs0", fwd_rd1, 32'h8);
`endif

    // Asynchronous reset in mid-cycle while a write is pending.
    drive(1, 1, 0, 3'd0, 32'h0000_0055, 5'd4, 32'h0);
    tick("pre_reset");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_reset.rw", 32'(regwrite), 32'd0);
    check_all("async_reset");
    rst = 1'b1;
    drive(1, 1, 0, 3'd0, 32'h0000_0001, 5'd1, 32'h0);
    tick("post_reset");
    check("post_reset.const_count", retired_count, 32'd1);

    // Randomized traffic; 4-bit counter wraps many times.
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) < 1);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), $urandom);
`ifdef WB_BYPASS_EN
      rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
      rf_rd1 = $urandom; rf_rd2 = $urandom;
      if ($urandom_range(0, 1) == 1) rs = exmem_dest;
`endif
      tick($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
